// File: rtl/line_nav_sequencer.sv
// -----------------------------------------------------------------------------
// line_nav_sequencer
//
// Upstream stage of the SB1287 motor driver. Debounces three IR line sensors,
// follows the line, detects junctions (all three sensors on the line) and
// executes a pre-programmed action per junction taken from PATH. The run stops
// in DONE at the junction after the last programmed one.
//
// Optional feature macro: LINE_LOST_RECOVERY_EN
//   defined   -> a LOST state reverses the robot while all sensors read 0
//   undefined -> motion is held while all sensors read 0, lost is tied to 0
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   start        in   single-cycle pulse, begins a run from IDLE or DONE
//   sensor[2:0]  in   raw sensors: [2] left, [1] centre, [0] right; 1 = on line
//   motion[2:0]  out  0 stop, 1 fwd, 2 left, 3 right, 4 reverse,
//                     5 left_turn, 6 right_turn
//   busy         out  high in every state except IDLE and DONE
//   done         out  high in DONE
//   junction_idx out  junctions passed in the current run (saturates at 8)
//   lost         out  line-lost indicator
// -----------------------------------------------------------------------------
module line_nav_sequencer #(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          CROSS_CYCLES    = 200,
    parameter int          TURN_CYCLES     = 400,
    parameter int          UTURN_CYCLES    = 900,
    parameter int          NUM_JUNCTIONS   = 4,
    parameter logic [15:0] PATH            = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sensor,
    output logic [2:0] motion,
    output logic       busy,
    output logic       done,
    output logic [3:0] junction_idx,
    output logic       lost
);

    localparam logic [7:0]  DEB_N   = 8'(DEBOUNCE_CYCLES);
    localparam logic [16:0] CROSS_N = 17'(CROSS_CYCLES);
    localparam logic [15:0] TURN_N  = 16'(TURN_CYCLES);
    localparam logic [15:0] UTURN_N = 16'(UTURN_CYCLES);
    localparam logic [3:0]  NJ      = 4'(NUM_JUNCTIONS);

    localparam logic [2:0] M_STOP  = 3'd0;
    localparam logic [2:0] M_FWD   = 3'd1;
    localparam logic [2:0] M_LEFT  = 3'd2;
    localparam logic [2:0] M_RIGHT = 3'd3;
    localparam logic [2:0] M_REV   = 3'd4;
    localparam logic [2:0] M_LTURN = 3'd5;
    localparam logic [2:0] M_RTURN = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FOLLOW,
        S_CROSS,
        S_TURN_L,
        S_TURN_R,
        S_UTURN,
        S_DONE
`ifdef LINE_LOST_RECOVERY_EN
        , S_LOST
`endif
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc_idx(input logic [3:0] v);
        return (v >= 4'd8) ? 4'd8 : v + 4'd1;
    endfunction

    // Line-following steering; 000 keeps the previous command.
    function automatic logic [2:0] follow_motion(input logic [2:0] f,
                                                 input logic [2:0] prev);
        case (f)
            3'b010, 3'b101, 3'b111: return M_FWD;
            3'b110, 3'b100:         return M_LEFT;
            3'b011, 3'b001:         return M_RIGHT;
            default:                return prev;
        endcase
    endfunction

    // ---- stage p0: raw sensor sample ----
    logic [2:0] sensor_p0;

    // ---- stage p1: debounce (candidate pattern, run length, filtered F) ----
    logic [2:0] cand_p1;
    logic [2:0] filt_p1;
    logic [7:0] deb_cnt;
    logic [7:0] deb_cnt_next;

    // A new pattern restarts the run at 1 so that the sample itself counts.
    always_comb begin
        deb_cnt_next = (sensor_p0 != cand_p1) ? 8'd1 : sat_inc8(deb_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sensor_p0 <= 3'b000;
            cand_p1   <= 3'b000;
            filt_p1   <= 3'b000;
            deb_cnt   <= 8'd0;
        end else begin
            sensor_p0 <= sensor;
            cand_p1   <= sensor_p0;
            deb_cnt   <= deb_cnt_next;
            if (deb_cnt_next >= DEB_N)
                filt_p1 <= sensor_p0;
        end
    end

    // ---- stage p2: sequencer FSM and registered outputs ----
    state_t      state, state_next;
    logic [15:0] phase_cnt, phase_next;
    logic [1:0]  action, action_next;
    logic [3:0]  idx_next;
    logic [2:0]  motion_next;
    logic        busy_next;
    logic        done_next;

    always_comb begin
        state_next  = state;
        action_next = action;
        idx_next    = junction_idx;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_FOLLOW;
                    idx_next   = 4'd0;
                end
            end
            S_FOLLOW: begin
                if (filt_p1 == 3'b111) begin
                    if (junction_idx == NJ) begin
                        state_next = S_DONE;
                    end else begin
                        action_next = PATH[{junction_idx[2:0], 1'b0} +: 2];
                        idx_next    = sat_inc_idx(junction_idx);
                        state_next  = S_CROSS;
                    end
                end
`ifdef LINE_LOST_RECOVERY_EN
                else if (filt_p1 == 3'b000) begin
                    state_next = S_LOST;
                end
`endif
            end
            S_CROSS: begin
                // The cycle with phase_cnt == CROSS_CYCLES-1 is the last one.
                if (({1'b0, phase_cnt} + 17'd1) >= CROSS_N) begin
                    case (action)
                        2'd0:    state_next = S_FOLLOW;
                        2'd1:    state_next = S_TURN_L;
                        2'd2:    state_next = S_TURN_R;
                        default: state_next = S_UTURN;
                    endcase
                end
            end
            S_TURN_L, S_TURN_R: begin
                if (phase_cnt >= TURN_N && filt_p1[1])
                    state_next = S_FOLLOW;
            end
            S_UTURN: begin
                if (phase_cnt >= UTURN_N && filt_p1[1])
                    state_next = S_FOLLOW;
            end
`ifdef LINE_LOST_RECOVERY_EN
            S_LOST: begin
                if (filt_p1 != 3'b000)
                    state_next = S_FOLLOW;
            end
`endif
            default: state_next = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_next)
            S_FOLLOW:           motion_next = follow_motion(filt_p1, motion);
            S_CROSS:            motion_next = M_FWD;
            S_TURN_L:           motion_next = M_LTURN;
            S_TURN_R, S_UTURN:  motion_next = M_RTURN;
`ifdef LINE_LOST_RECOVERY_EN
            S_LOST:             motion_next = M_REV;
`endif
            default:            motion_next = M_STOP;
        endcase

        busy_next  = (state_next != S_IDLE) && (state_next != S_DONE);
        done_next  = (state_next == S_DONE);
        phase_next = (state_next != state) ? 16'd0 : sat_inc16(phase_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            phase_cnt    <= 16'd0;
            action       <= 2'd0;
            junction_idx <= 4'd0;
            motion       <= M_STOP;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            phase_cnt    <= phase_next;
            action       <= action_next;
            junction_idx <= idx_next;
            motion       <= motion_next;
            busy         <= busy_next;
            done         <= done_next;
        end
    end

`ifdef LINE_LOST_RECOVERY_EN
    logic lost_q;

    always_ff @(posedge clk) begin
        if (rst)
            lost_q <= 1'b0;
        else
            lost_q <= (state_next == S_LOST);
    end

    assign lost = lost_q;
`else
    assign lost = 1'b0;
`endif

endmodule

// File: tb/tb_line_nav_sequencer.sv
// -----------------------------------------------------------------------------
// tb_line_nav_sequencer
//
// Directed bench for line_nav_sequencer with shortened phase times. Expected
// motion changes are queued as stimulus is driven and a monitor pops and
// compares them whenever motion changes; point checks cover reset, debounce
// latency, junction counting, turn exit timing, DONE, line-lost and reset
// during a U-turn.
// -----------------------------------------------------------------------------
module tb_line_nav_sequencer;

    localparam int          DEB = 4;
    localparam int          CRS = 20;
    localparam int          TRN = 40;
    localparam int          UTN = 120;
    localparam int          NJ  = 4;
    localparam logic [15:0] PTH = 16'h00E4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sensor;
    logic [2:0] motion;
    logic       busy;
    logic       done;
    logic [3:0] junction_idx;
    logic       lost;

    line_nav_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .CROSS_CYCLES    (CRS),
        .TURN_CYCLES     (TRN),
        .UTURN_CYCLES    (UTN),
        .NUM_JUNCTIONS   (NJ),
        .PATH            (PTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sensor       (sensor),
        .motion       (motion),
        .busy         (busy),
        .done         (done),
        .junction_idx (junction_idx),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;
    logic [2:0] exp_q[$];
    bit         sb_on = 1'b0;
    logic [2:0] prev_motion = 3'd0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Scoreboard monitor: every motion change must match the next queued value.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_on && (motion !== prev_motion)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $error("FAIL sb_unexpected: observed %0d expected no change from %0d",
                           motion, prev_motion);
                end else begin
                    check("sb_motion", 16'(motion), 16'(exp_q.pop_front()));
                end
            end
            prev_motion = motion;
        end
    end

    // One junction from FOLLOW (F = 010): act 0 straight, 1 left, 2 right, 3 U-turn.
    // extra == 0: centre sensor returns at pivot entry, exit lands exactly at the minimum.
    // extra  > 0: centre stays off line for extra cycles beyond the minimum.
    task automatic do_junction(input int k, input int act, input int extra);
        logic [2:0] pm;
        int         mint;
        pm   = (act == 1) ? 3'd5 : 3'd6;
        mint = (act == 3) ? UTN : TRN;
        sensor = 3'b111;
        cyc(DEB + 2);
        check($sformatf("j%0d_idx", k), 16'(junction_idx), 16'(k + 1));
        check($sformatf("j%0d_cross_motion", k), 16'(motion), 16'd1);
        if (act == 0) begin
            sensor = 3'b010;
            cyc(CRS + 5);
            check($sformatf("j%0d_straight_follow", k), 16'(motion), 16'd1);
            check($sformatf("j%0d_busy", k), 16'(busy), 16'd1);
        end else begin
            exp_q.push_back(pm);
            sensor = 3'b000;
            cyc(CRS);
            check($sformatf("j%0d_pivot_motion", k), 16'(motion), 16'(pm));
            exp_q.push_back(3'd1);
            if (extra == 0) begin
                sensor = 3'b010;
                cyc(mint);
                check($sformatf("j%0d_pivot_min_hold", k), 16'(motion), 16'(pm));
                cyc(1);
                check($sformatf("j%0d_pivot_exit", k), 16'(motion), 16'd1);
            end else begin
                cyc(mint + extra);
                check($sformatf("j%0d_pivot_no_centre", k), 16'(motion), 16'(pm));
                sensor = 3'b010;
                cyc(DEB + 1);
                check($sformatf("j%0d_pivot_deb_hold", k), 16'(motion), 16'(pm));
                cyc(1);
                check($sformatf("j%0d_pivot_exit", k), 16'(motion), 16'd1);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sensor = 3'b111;
        cyc(3);
        check("rst_motion", 16'(motion), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_idx", 16'(junction_idx), 16'd0);
        check("rst_lost", 16'(lost), 16'd0);

        rst = 1'b0;
        pulse_start();
        check("start_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_busy_clear", 16'(busy), 16'd0);

        sensor = 3'b010;
        cyc(DEB + 4);
        sb_on = 1'b1;
        exp_q.push_back(3'd1);
        pulse_start();
        check("run_busy", 16'(busy), 16'd1);
        check("run_idx", 16'(junction_idx), 16'd0);
        check("run_motion", 16'(motion), 16'd1);

        // Debounce latency: change visible on motion exactly DEB+2 edges later.
        exp_q.push_back(3'd2);
        sensor = 3'b110;
        cyc(DEB + 1);
        check("deb_before", 16'(motion), 16'd1);
        cyc(1);
        check("deb_after", 16'(motion), 16'd2);
        exp_q.push_back(3'd1);
        sensor = 3'b010;
        cyc(DEB + 2);
        check("deb_back", 16'(motion), 16'd1);
        sensor = 3'b110;
        cyc(DEB - 1);
        sensor = 3'b010;
        cyc(10);
        check("deb_glitch", 16'(motion), 16'd1);

        // PATH 00E4: straight, left (held beyond minimum), right, U-turn.
        do_junction(0, 0, 0);
        do_junction(1, 1, 30);
        do_junction(2, 2, 0);
        do_junction(3, 3, 0);

        exp_q.push_back(3'd0);
        sensor = 3'b111;
        cyc(DEB + 2);
        check("done_motion", 16'(motion), 16'd0);
        check("done_flag", 16'(done), 16'd1);
        check("done_busy", 16'(busy), 16'd0);
        check("done_idx", 16'(junction_idx), 16'd4);

        // Line lost from a right-steering FOLLOW.
        sensor = 3'b011;
        cyc(DEB + 2);
        check("done_hold", 16'(done), 16'd1);
        exp_q.push_back(3'd3);
        pulse_start();
        check("restart_motion", 16'(motion), 16'd3);
        check("restart_idx", 16'(junction_idx), 16'd0);
        check("restart_done", 16'(done), 16'd0);
`ifdef LINE_LOST_RECOVERY_EN
        exp_q.push_back(3'd4);
`endif
        sensor = 3'b000;
        cyc(DEB + 2);
`ifdef LINE_LOST_RECOVERY_EN
        check("lost_motion", 16'(motion), 16'd4);
        check("lost_flag", 16'(lost), 16'd1);
`else
        check("lost_motion", 16'(motion), 16'd3);
        check("lost_flag", 16'(lost), 16'd0);
`endif
        exp_q.push_back(3'd1);
        sensor = 3'b010;
        cyc(DEB + 2);
        check("recover_motion", 16'(motion), 16'd1);
        check("recover_lost", 16'(lost), 16'd0);

        // Second run, reset 100 cycles into the U-turn.
        do_junction(0, 0, 0);
        do_junction(1, 1, 0);
        do_junction(2, 2, 0);
        exp_q.push_back(3'd6);
        sensor = 3'b111;
        cyc(DEB + 2);
        check("u_idx", 16'(junction_idx), 16'd4);
        sensor = 3'b000;
        cyc(CRS);
        check("u_motion", 16'(motion), 16'd6);
        cyc(100);
        check("u_still", 16'(motion), 16'd6);
        sb_on = 1'b0;
        rst   = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("u_rst_motion", 16'(motion), 16'd0);
        check("u_rst_busy", 16'(busy), 16'd0);
        check("u_rst_idx", 16'(junction_idx), 16'd0);
        check("u_rst_done", 16'(done), 16'd0);
        cyc(UTN);
        check("u_rst_no_resume", 16'(motion), 16'd0);
        sensor = 3'b010;
        cyc(DEB + 4);
        sb_on = 1'b1;
        exp_q.push_back(3'd1);
        pulse_start();
        check("u_restart_busy", 16'(busy), 16'd1);
        check("u_restart_idx", 16'(junction_idx), 16'd0);
        check("u_restart_motion", 16'(motion), 16'd1);
        cyc(4);

        check("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
